world_stream_loader: RTL and testbench

- Parametrised successor to the ad-hoc world-initialisation counters in the top level.
- Takes the received-byte stream from uart_receiver, frames it with a sync byte, and unpacks one block per byte.
- Generates L3-cache write coordinates in a configurable traversal order under a valid/ready handshake, then verifies an XOR checksum.
- Provides done/error status that gates cache reads.

---
 rtl/world_stream_loader.sv | 218 +++++++++++++++++++++
 tb/tb_world_stream_loader.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/world_stream_loader.sv
// world_stream_loader
//   Frames the UART byte stream with a sync byte, unpacks one block per payload
//   byte into a single pending write register, walks the L3 write coordinates in
//   the configured order under a valid/ready handshake, then compares the
//   trailing XOR checksum byte. done/error status gates cache reads.
//
// Ports
//   clk_in, rst_n_in        clock, async active-low reset
//   byte_valid_in, byte_in  one-cycle received-byte strobe and data
//   wr_ready_in             cache accepts the pending write this cycle
//   wr_valid_out            pending write (x/y/z_out, block_out)
//   busy_out                frame in progress (LOAD or CHECK)
//   done_out, error_out     sticky frame status until the next sync byte
//   err_code_out            0 none, 1 checksum, 2 overrun, 3 timeout
//   count_out               writes accepted in the current frame
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | after reset, waiting for the sync byte
// S_LOAD  | accepting the N payload bytes
// S_CHECK | waiting for the checksum byte and for the last write to drain
// S_DONE  | frame loaded, checksum matched
// S_ERROR | frame failed, cause in err_code_out
module world_stream_loader #(
    parameter int          LENGTH         = 64,
    parameter int          WIDTH          = 64,
    parameter int          HEIGHT         = 16,
    parameter int          BLOCK_BITS     = 5,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          ORDER          = 0,
    parameter int          TIMEOUT_CYCLES = 1_000_000,
    // An extent of 1 still gets a 1-bit coordinate so the port never collapses to zero width.
    localparam int         XW = (LENGTH > 1) ? $clog2(LENGTH) : 1,
    localparam int         YW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1,
    localparam int         ZW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1,
    localparam int         N  = LENGTH * WIDTH * HEIGHT,
    localparam int         CW = $clog2(N + 1)
) (
    input  logic                  clk_in,
    input  logic                  rst_n_in,
    input  logic                  byte_valid_in,
    input  logic [7:0]            byte_in,
    input  logic                  wr_ready_in,
    output logic                  wr_valid_out,
    output logic [XW-1:0]         x_out,
    output logic [YW-1:0]         y_out,
    output logic [ZW-1:0]         z_out,
    output logic [BLOCK_BITS-1:0] block_out,
    output logic                  busy_out,
    output logic                  done_out,
    output logic                  error_out,
    output logic [1:0]            err_code_out,
    output logic [CW-1:0]         count_out
);

    localparam int             TW          = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0]  TIMER_LOAD  = TW'(TIMEOUT_CYCLES);
    localparam logic [XW-1:0]  X_MAX       = XW'(LENGTH - 1);
    localparam logic [YW-1:0]  Y_MAX       = YW'(WIDTH - 1);
    localparam logic [ZW-1:0]  Z_MAX       = ZW'(HEIGHT - 1);
    localparam logic [CW-1:0]  N_LAST      = CW'(N - 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_CHECK, S_DONE, S_ERROR} state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  rx_cnt;
    logic [7:0]     csum;
    logic [7:0]     chk_byte;
    logic           chk_seen;
    logic [TW-1:0]  timer;

    logic           sync_hit, hs, overrun, timeout_hit, chk_have, resolve;
    logic [7:0]     chk_val;
    logic [1:0]     err_val;
    logic           x_last, y_last, z_last;
    logic [XW-1:0]  x_nx;
    logic [YW-1:0]  y_nx;
    logic [ZW-1:0]  z_nx;

    assign sync_hit    = byte_valid_in && (byte_in == SYNC_BYTE);
    assign hs          = wr_valid_out && wr_ready_in;
    assign overrun     = (state == S_LOAD) && byte_valid_in && wr_valid_out && !wr_ready_in;
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((state == S_LOAD) || (state == S_CHECK))
                         && !byte_valid_in && (timer == '0);
    // The checksum byte may arrive while the last write is still stalled; it is held until drain.
    assign chk_have    = chk_seen || ((state == S_CHECK) && byte_valid_in);
    assign chk_val     = chk_seen ? chk_byte : byte_in;
    // A write that handshakes this cycle counts as drained, so done follows the final handshake by one cycle.
    assign resolve     = (state == S_CHECK) && chk_have && (!wr_valid_out || hs);

    assign busy_out  = (state == S_LOAD) || (state == S_CHECK);
    assign done_out  = (state == S_DONE);
    assign error_out = (state == S_ERROR);

    assign x_last = (x_out == X_MAX);
    assign y_last = (y_out == Y_MAX);
    assign z_last = (z_out == Z_MAX);

    always_comb begin
        x_nx = x_out;
        y_nx = y_out;
        z_nx = z_out;
        if (ORDER == 0) begin
            x_nx = x_last ? '0 : x_out + 1'b1;
            if (x_last) begin
                y_nx = y_last ? '0 : y_out + 1'b1;
                if (y_last) z_nx = z_last ? '0 : z_out + 1'b1;
            end
        end else begin
            z_nx = z_last ? '0 : z_out + 1'b1;
            if (z_last) begin
                y_nx = y_last ? '0 : y_out + 1'b1;
                if (y_last) x_nx = x_last ? '0 : x_out + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) state <= S_IDLE;
        else           state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        err_val  = 2'd0;
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (sync_hit) state_nx = S_LOAD;
            end
            S_LOAD: begin
                if (overrun) begin
                    state_nx = S_ERROR;
                    err_val  = 2'd2;
                end else if (timeout_hit) begin
                    state_nx = S_ERROR;
                    err_val  = 2'd3;
                end else if (byte_valid_in && (rx_cnt == N_LAST)) begin
                    state_nx = S_CHECK;
                end
            end
            S_CHECK: begin
                if (resolve) begin
                    if (chk_val == csum) begin
                        state_nx = S_DONE;
                    end else begin
                        state_nx = S_ERROR;
                        err_val  = 2'd1;
                    end
                end else if (timeout_hit) begin
                    state_nx = S_ERROR;
                    err_val  = 2'd3;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_valid_out <= 1'b0;
            x_out        <= '0;
            y_out        <= '0;
            z_out        <= '0;
            block_out    <= '0;
            err_code_out <= 2'd0;
            count_out    <= '0;
            rx_cnt       <= '0;
            csum         <= 8'd0;
            chk_byte     <= 8'd0;
            chk_seen     <= 1'b0;
            timer        <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (sync_hit) begin
                        x_out        <= '0;
                        y_out        <= '0;
                        z_out        <= '0;
                        count_out    <= '0;
                        rx_cnt       <= '0;
                        csum         <= 8'd0;
                        chk_seen     <= 1'b0;
                        err_code_out <= 2'd0;
                        timer        <= TIMER_LOAD;
                    end
                end
                S_LOAD, S_CHECK: begin
                    if (hs) begin
                        x_out        <= x_nx;
                        y_out        <= y_nx;
                        z_out        <= z_nx;
                        count_out    <= count_out + 1'b1;
                        wr_valid_out <= 1'b0;
                    end
                    // A new byte in the handshake cycle overrides the drop above: no bubble.
                    if ((state == S_LOAD) && byte_valid_in && !overrun) begin
                        block_out    <= byte_in[BLOCK_BITS-1:0];
                        wr_valid_out <= 1'b1;
                        csum         <= csum ^ byte_in;
                        rx_cnt       <= rx_cnt + 1'b1;
                    end
                    if ((state == S_CHECK) && byte_valid_in && !chk_seen) begin
                        chk_seen <= 1'b1;
                        chk_byte <= byte_in;
                    end
                    if (byte_valid_in)      timer <= TIMER_LOAD;
                    else if (timer != '0)   timer <= timer - 1'b1;
                    if (state_nx == S_ERROR) begin
                        wr_valid_out <= 1'b0;
                        err_code_out <= err_val;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_world_stream_loader.sv
// Directed bench for world_stream_loader: unit 0 is a 2x2x2 ORDER=0 loader with a
// 16-cycle timeout, unit 1 is a 3x1x2 ORDER=1 loader with the timeout disabled.
module tb_world_stream_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       bv  [2];
    logic [7:0] bd  [2];
    logic       rdy [2];

    logic       a_wv, a_busy, a_done, a_err;
    logic [0:0] a_x, a_y, a_z;
    logic [4:0] a_blk;
    logic [1:0] a_code;
    logic [3:0] a_cnt;

    logic       b_wv, b_busy, b_done, b_err;
    logic [1:0] b_x;
    logic [0:0] b_y, b_z;
    logic [4:0] b_blk;
    logic [1:0] b_code;
    logic [2:0] b_cnt;

    world_stream_loader #(.LENGTH(2), .WIDTH(2), .HEIGHT(2), .ORDER(0), .TIMEOUT_CYCLES(16)) u_a (
        .clk_in(clk), .rst_n_in(rst_n), .byte_valid_in(bv[0]), .byte_in(bd[0]),
        .wr_ready_in(rdy[0]), .wr_valid_out(a_wv), .x_out(a_x), .y_out(a_y), .z_out(a_z),
        .block_out(a_blk), .busy_out(a_busy), .done_out(a_done), .error_out(a_err),
        .err_code_out(a_code), .count_out(a_cnt));

    world_stream_loader #(.LENGTH(3), .WIDTH(1), .HEIGHT(2), .ORDER(1), .TIMEOUT_CYCLES(0)) u_b (
        .clk_in(clk), .rst_n_in(rst_n), .byte_valid_in(bv[1]), .byte_in(bd[1]),
        .wr_ready_in(rdy[1]), .wr_valid_out(b_wv), .x_out(b_x), .y_out(b_y), .z_out(b_z),
        .block_out(b_blk), .busy_out(b_busy), .done_out(b_done), .error_out(b_err),
        .err_code_out(b_code), .count_out(b_cnt));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {int x; int y; int z; int b;} wr_t;
    wr_t qa[$];
    wr_t qb[$];

    always @(negedge clk) begin
        if (a_wv && rdy[0]) qa.push_back('{int'(a_x), int'(a_y), int'(a_z), int'(a_blk)});
        if (b_wv && rdy[1]) qb.push_back('{int'(b_x), int'(b_y), int'(b_z), int'(b_blk)});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input int u, input logic [7:0] b);
        bv[u] = 1'b1;
        bd[u] = b;
        step(1);
        bv[u] = 1'b0;
    endtask

    logic [7:0] frame2 [8];
    int         blk2   [8];

    initial begin
        frame2 = '{8'hE1, 8'h42, 8'h84, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
        blk2   = '{1, 2, 4, 8, 16, 0, 0, 0};
        rst_n = 1'b0;
        for (int u = 0; u < 2; u++) begin
            bv[u]  = 1'b0;
            bd[u]  = 8'h00;
            rdy[u] = 1'b1;
        end
        step(2);
        chk("rst_wv",   a_wv,   0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_err",  a_err,  0);
        chk("rst_cnt",  a_cnt,  0);
        chk("rst_b_x",  b_x,    0);
        rst_n = 1'b1;
        step(2);

        // ORDER=1, non-power-of-2 x extent
        send(1, 8'hA5);
        for (int i = 0; i < 6; i++) send(1, 8'(i));
        send(1, 8'h01);
        step(3);
        chk("b_done", b_done, 1);
        chk("b_err",  b_err,  0);
        chk("b_cnt",  b_cnt,  6);
        chk("b_nwr",  qb.size(), 6);
        for (int i = 0; i < 6 && i < qb.size(); i++) begin
            chk("b_x",   qb[i].x, i / 2);
            chk("b_y",   qb[i].y, 0);
            chk("b_z",   qb[i].z, i % 2);
            chk("b_blk", qb[i].b, i);
        end

        // basic load, ORDER=0
        qa.delete();
        send(0, 8'hA5);
        chk("basic_busy_start", a_busy, 1);
        for (int i = 0; i < 8; i++) send(0, 8'(i));
        send(0, 8'h00);
        step(3);
        chk("basic_done", a_done, 1);
        chk("basic_err",  a_err,  0);
        chk("basic_cnt",  a_cnt,  8);
        chk("basic_busy", a_busy, 0);
        chk("basic_nwr",  qa.size(), 8);
        for (int i = 0; i < 8 && i < qa.size(); i++) begin
            chk("basic_x",   qa[i].x, i & 1);
            chk("basic_y",   qa[i].y, (i >> 1) & 1);
            chk("basic_z",   qa[i].z, i >> 2);
            chk("basic_blk", qa[i].b, i);
        end

        // checksum mismatch
        qa.delete();
        send(0, 8'hA5);
        chk("mm_done_cleared", a_done, 0);
        for (int i = 0; i < 8; i++) send(0, 8'(i));
        send(0, 8'hFF);
        step(3);
        chk("mm_err",  a_err,  1);
        chk("mm_code", a_code, 1);
        chk("mm_done", a_done, 0);
        chk("mm_cnt",  a_cnt,  8);
        chk("mm_nwr",  qa.size(), 8);

        // backpressure, then overrun
        qa.delete();
        send(0, 8'hA5);
        chk("bp_err_cleared", a_err, 0);
        rdy[0] = 1'b0;
        send(0, 8'h11);
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("bp_wv_stall", a_wv,  1);
            chk("bp_x_stall",  a_x,   0);
            chk("bp_blk_stall", a_blk, 17);
            chk("bp_cnt_stall", a_cnt, 0);
        end
        rdy[0] = 1'b1;
        send(0, 8'h22);
        rdy[0] = 1'b0;
        chk("bp_err",  a_err, 0);
        chk("bp_wv",   a_wv,  1);
        chk("bp_x",    a_x,   1);
        chk("bp_blk",  a_blk, 2);
        chk("bp_cnt",  a_cnt, 1);
        chk("bp_nwr",  qa.size(), 1);
        send(0, 8'h33);
        chk("ovr_err",  a_err,  1);
        chk("ovr_code", a_code, 2);
        chk("ovr_wv",   a_wv,   0);
        chk("ovr_busy", a_busy, 0);
        rdy[0] = 1'b1;

        // timeout, then restart with a full frame
        send(0, 8'hA5);
        send(0, 8'h01);
        send(0, 8'h02);
        send(0, 8'h03);
        step(16);
        chk("to_err_early", a_err,  0);
        chk("to_busy_early", a_busy, 1);
        step(1);
        chk("to_err",  a_err,  1);
        chk("to_code", a_code, 3);
        chk("to_busy", a_busy, 0);
        qa.delete();
        send(0, 8'hA5);
        chk("rs_err",  a_err,  0);
        chk("rs_code", a_code, 0);
        chk("rs_busy", a_busy, 1);
        for (int i = 0; i < 8; i++) send(0, frame2[i]);
        send(0, 8'hDF);
        step(3);
        chk("rs_done", a_done, 1);
        chk("rs_err2", a_err,  0);
        chk("rs_cnt",  a_cnt,  8);
        chk("rs_nwr",  qa.size(), 8);
        for (int i = 0; i < 8 && i < qa.size(); i++) chk("rs_blk", qa[i].b, blk2[i]);

        // async reset mid-frame
        send(0, 8'hA5);
        send(0, 8'h00);
        send(0, 8'h01);
        chk("ar_wv_pre",  a_wv,  1);
        chk("ar_cnt_pre", a_cnt, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_wv",   a_wv,   0);
        chk("ar_busy", a_busy, 0);
        chk("ar_cnt",  a_cnt,  0);
        chk("ar_done", a_done, 0);
        step(1);
        rst_n = 1'b1;
        qa.delete();
        step(1);
        send(0, 8'h11);
        send(0, 8'h22);
        step(2);
        chk("ar_stray_nwr",  qa.size(), 0);
        chk("ar_stray_busy", a_busy, 0);
        chk("ar_stray_wv",   a_wv,   0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
